// File: rtl/demux8_rr_sched.sv
// demux8_rr_sched: one-word buffer that demuxes each accepted word
// to one of 8 enabled channels, chosen round-robin.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready upstream handshake, in_data upstream word
//   chan_en[7:0]      channel eligibility mask
//   out_ready[7:0]    per-channel downstream ready
//   out_valid[7:0]    one-hot valid toward the selected channel
//   out_data          held word, shared by all channels
//   sel[2:0]          index of the current target channel
//   busy              a word is held
//   drop_cnt[7:0]     saturating count of dropped words
module demux8_rr_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [7:0]       chan_en,
  input  logic [7:0]       out_ready,
  output logic [7:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] hold_q;
  logic [2:0]       ptr_q;
  logic [2:0]       sel_q;
  logic [7:0]       drop_q;

  logic any_en;
  logic sel_en;
  logic accept;
  logic done;
  logic drop;
  logic move;

  // First set bit of m scanning start, start+1, ... (mod 8).
  // Scanning from the far end lets the nearest hit win.
  function automatic logic [2:0] first_en(
    input logic [7:0] m,
    input logic [2:0] start
  );
    logic [2:0] idx;
    logic [2:0] pos;
    idx = start;
    for (int k = 7; k >= 0; k--) begin
      pos = start + 3'(k);
      if (m[pos])
        idx = pos;
    end
    return idx;
  endfunction

  assign any_en = |chan_en;
  assign sel_en = chan_en[sel_q];

  assign accept = (state_q == IDLE)
                & in_valid & any_en;
  assign drop   = (state_q == HOLD) & ~any_en;
  assign move   = (state_q == HOLD)
                & any_en & ~sel_en;
  assign done   = (state_q == HOLD)
                & sel_en & out_ready[sel_q];

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)      state_d = HOLD;
      HOLD: if (done | drop) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 8'h00;
    out_data  = '0;
    if (rst_n) begin
      out_data = hold_q;
      case (state_q)
        IDLE: in_ready = any_en;
        HOLD: begin
          busy      = 1'b1;
          out_valid = 8'h01 << sel_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      ptr_q  <= 3'd0;
      sel_q  <= 3'd0;
      drop_q <= 8'd0;
    end else begin
      if (accept) begin
        hold_q <= in_data;
        sel_q  <= first_en(chan_en, ptr_q);
      end
      // sel itself is disabled here, so a scan from
      // sel+1 can only land on another channel
      if (move)
        sel_q <= first_en(chan_en, sel_q + 3'd1);
      if (done)
        ptr_q <= sel_q + 3'd1;
      if (drop && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  assign sel      = sel_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux8_rr_sched.sv
// tb_demux8_rr_sched: directed and random stimulus for
// demux8_rr_sched, checked against a transaction-level model.
module tb_demux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] chan_en;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  // model: is a word held, which word, target, pointer, drops
  bit m_busy;
  int m_word;
  int m_sel;
  int m_ptr;
  int m_drops;

  always #5 clk = ~clk;

  demux8_rr_sched #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .chan_en   (chan_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // nearest enabled channel at or after start, wrapping
  function automatic int next_en(
    input logic [7:0] en,
    input int         start
  );
    for (int k = 0; k < 8; k++)
      if (en[(start + k) % 8])
        return (start + k) % 8;
    return start % 8;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle,
  // then advance the model to match the coming edge.
  task automatic cyc(
    input bit         r,
    input bit         v,
    input logic [7:0] d,
    input logic [7:0] en,
    input logic [7:0] rdy
  );
    rst_n     = r;
    in_valid  = v;
    in_data   = d;
    chan_en   = en;
    out_ready = rdy;
    @(negedge clk);
    if (!r) begin
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_data", out_data, 0);
      m_busy  = 0;
      m_word  = 0;
      m_sel   = 0;
      m_ptr   = 0;
      m_drops = 0;
    end else begin
      check("sel", sel, m_sel);
      check("drop_cnt", drop_cnt, m_drops);
      check("busy", busy, m_busy);
      if (!m_busy) begin
        check("idle_valid", out_valid, 0);
        check("idle_ready", in_ready, en != 0);
        if (v && en != 0) begin
          m_word = d;
          m_sel  = next_en(en, m_ptr);
          m_busy = 1;
        end
      end else begin
        check("hold_valid", out_valid, 1 << m_sel);
        check("hold_ready", in_ready, 0);
        check("hold_data", out_data, m_word);
        if (en == 0) begin
          if (m_drops < 255)
            m_drops++;
          m_busy = 0;
        end else if (!en[m_sel]) begin
          m_sel = next_en(en, m_sel + 1);
        end else if (rdy[m_sel]) begin
          m_busy = 0;
          m_ptr  = (m_sel + 1) % 8;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_busy  = 0;
    m_word  = 0;
    m_sel   = 0;
    m_ptr   = 0;
    m_drops = 0;
    #1;
    cyc(0, 0, 8'h00, 8'hFF, 8'hFF);
    cyc(0, 1, 8'h55, 8'hFF, 8'hFF);
    check("reset_sel", sel, 0);
    check("reset_drops", drop_cnt, 0);

    // back-to-back round robin over all channels
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, 8'(8'h10 + i), 8'hFF, 8'hFF);
      check("rr_sel", sel, i % 8);
      check("rr_valid", out_valid, 1 << (i % 8));
      check("rr_data", out_data, 8'h10 + i);
      cyc(1, 0, 8'h00, 8'hFF, 8'hFF);
    end

    // sparse mask
    cyc(0, 0, 8'h00, 8'hFF, 8'hFF);
    begin
      int exp_sel[4] = '{2, 5, 7, 2};
      for (int i = 0; i < 4; i++) begin
        cyc(1, 1, 8'(i), 8'hA4, 8'hFF);
        check("sparse_sel", sel, exp_sel[i]);
        cyc(1, 0, 8'h00, 8'hA4, 8'hFF);
      end
    end

    // backpressure: word waits on channel 0
    cyc(0, 0, 8'h00, 8'hFF, 8'hFF);
    cyc(1, 1, 8'hAA, 8'hFF, 8'h00);
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 8'(i), 8'hFF, 8'h00);
    check("bp_data", out_data, 8'hAA);
    cyc(1, 0, 8'h00, 8'hFF, 8'h01);
    check("bp_done", busy, 0);

    // channel disabled while held, then all disabled
    cyc(0, 0, 8'h00, 8'hFF, 8'hFF);
    cyc(1, 1, 8'h3C, 8'h08, 8'h00);
    check("mv_sel3", sel, 3);
    cyc(1, 1, 8'hC3, 8'hF7, 8'h00);
    check("mv_sel4", sel, 4);
    check("mv_valid", out_valid, 8'h10);
    check("mv_data", out_data, 8'h3C);
    cyc(1, 0, 8'h00, 8'h00, 8'hFF);
    check("drop_one", drop_cnt, 1);
    cyc(1, 1, 8'h00, 8'h00, 8'hFF);

    // reset while holding
    cyc(1, 1, 8'h77, 8'hFF, 8'h00);
    cyc(1, 0, 8'h00, 8'hFF, 8'h00);
    cyc(0, 0, 8'h00, 8'hFF, 8'h00);
    check("hrst_sel", sel, 0);
    check("hrst_valid", out_valid, 0);
    cyc(1, 1, 8'h99, 8'h30, 8'h00);
    check("hrst_first", sel, 4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit         r;
      logic [7:0] en;
      r  = ($urandom_range(0, 99) != 0);
      en = ($urandom_range(0, 4) == 0)
           ? 8'h00 : 8'($urandom);
      cyc(r, 1'($urandom), 8'($urandom), en,
          8'($urandom));
    end

    // saturating drop counter
    cyc(0, 0, 8'h00, 8'hFF, 8'hFF);
    for (int i = 0; i < 257; i++) begin
      cyc(1, 1, 8'(i), 8'hFF, 8'h00);
      cyc(1, 0, 8'h00, 8'h00, 8'h00);
      if (i == 254)
        check("sat_255", drop_cnt, 255);
    end
    check("sat_hold", drop_cnt, 255);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/demux8_rr_sched.md
DEMUX8_RR_SCHED -- requirements
Module: demux8_rr_sched

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream word available.
REQ-005 Port: in_data  input  WIDTH  upstream word.
REQ-006 Port: in_ready  output  1  block accepts the word this cycle; transfer = in_valid & in_ready.
REQ-007 Port: chan_en  input  8  per-channel enable mask; bit i = channel i eligible.
REQ-008 Port: out_ready  input  8  per-channel downstream ready.
REQ-009 Port: out_valid  output  8  one-hot (or zero) valid toward channel i.
REQ-010 Port: out_data  output  WIDTH  held word, shared by all channels.
REQ-011 Port: sel  output  3  binary index of the current target channel (demux select; sel[2]=S3, sel[1]=S2, sel[0]=S1).
REQ-012 Port: busy  output  1  high while a word is held.
REQ-013 Port: drop_cnt  output  8  count of dropped words, saturating.

Function
REQ-014 The block SHALL be a two-state FSM, IDLE and HOLD, with a single WIDTH-bit holding register and a 3-bit round-robin pointer ptr.
REQ-015 IDLE: in_ready SHALL equal |chan_en; out_valid SHALL be 0; busy SHALL be 0.
REQ-016 IDLE with in_valid & in_ready: the block SHALL capture in_data, set sel to the first i in order ptr, ptr+1, ... ptr+7 (mod 8) with chan_en[i]=1, and go to HOLD next cycle.
REQ-017 IDLE with chan_en==0: no word SHALL be accepted; state SHALL stay IDLE.
REQ-018 HOLD: in_ready SHALL be 0; busy SHALL be 1; out_valid SHALL be one-hot at bit sel; out_data SHALL equal the held word.
REQ-019 HOLD with out_ready[sel]=1 and chan_en[sel]=1: the transfer SHALL complete that cycle; next cycle state=IDLE and ptr=(sel+1) mod 8.
REQ-020 HOLD with chan_en[sel]=0: no transfer SHALL occur; next cycle sel SHALL move to the first enabled channel after sel (mod 8, excluding sel); the held word SHALL be kept.
REQ-021 HOLD with chan_en==0: the word SHALL be dropped; drop_cnt SHALL increment (saturating at 255); next state IDLE; ptr unchanged.
REQ-022 out_ready of non-selected channels SHALL be ignored; out_ready[sel] SHALL be ignored when chan_en[sel]=0.
REQ-023 Channel selection SHALL NOT depend on out_ready; the word waits indefinitely on an enabled, not-ready channel.
REQ-024 Throughput: at most one word per 2 cycles; accept-to-first-out_valid latency SHALL be 1 cycle.
REQ-025 ptr wrap: after a grant to channel 7, ptr SHALL be 0.
REQ-026 in_data and chan_en changes while in HOLD SHALL NOT alter the held word.

Reset
REQ-027 With rst_n=0 at a rising clk edge: state=IDLE, ptr=0, sel=0, holding register=0, drop_cnt=0.
REQ-028 While rst_n=0: out_valid=0, busy=0, in_ready=0, out_data=0.
REQ-029 Reset asserted in HOLD SHALL discard the held word without incrementing drop_cnt; the first cycle after release SHALL be IDLE.

Verification
REQ-030 chan_en=0xFF, out_ready=0xFF, 8 words 0x10..0x17 back-to-back -> sel 0..7 in order, out_valid=0x01,0x02,...,0x80, each word on its channel; 9th word -> channel 0.
REQ-031 chan_en=0b10100100, out_ready=0xFF, 4 words -> sel 2,5,7,2.
REQ-032 chan_en=0xFF, word 0xAA to channel 0, out_ready=0 for 5 cycles then out_ready[0]=1 -> out_valid=0x01 and out_data=0xAA held all 6 cycles, in_ready=0 throughout, transfer on 6th.
REQ-033 In HOLD on channel 3, clear chan_en[3] (chan_en=0xF7) -> next cycle sel=4, out_valid=0x10, same data; then chan_en=0 in HOLD -> drop_cnt 0->1, IDLE, in_ready=0.
REQ-034 rst_n=0 for one cycle while in HOLD -> out_valid=0, sel=0, drop_cnt=0; next accepted word targets first enabled channel from 0.
REQ-035 Force 256 drops -> drop_cnt reads 255 and stays 255.
